// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame generator.
package parity_pkg;

  typedef enum logic {
    ST_DATA    = 1'b0,
    ST_TRAILER = 1'b1
  } state_e;

  // Word counter width; a single-word frame still needs one bit of storage.
  function automatic int cnt_width(input int frame_len);
    return (frame_len <= 1) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/parity_frame_gen_xor_reduce.sv
// Combinational XOR reduction of a W-bit word (even-parity bit).
module xor_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  output logic         par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming vertical/longitudinal parity generator with valid/ready on both sides.
// Optional PARITY_FRAME_LAST_EN adds in_last to close a frame early.
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_odd,
  input  logic              in_valid,
`ifdef PARITY_FRAME_LAST_EN
  input  logic              in_last,
`endif
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_is_trailer
);

  localparam int            CW       = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  state_e              state_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   lrc_q;
  logic                out_valid_q, out_par_q, out_trl_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                in_par, lrc_par;
  logic                slot_free, accept, frame_end;

  xor_reduce #(.W(DATA_W)) u_in_par  (.data_i(in_data), .par_o(in_par));
  xor_reduce #(.W(DATA_W)) u_lrc_par (.data_i(lrc_q),   .par_o(lrc_par));

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_DATA) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    frame_end = (cnt_q == CNT_LAST);
`ifdef PARITY_FRAME_LAST_EN
    frame_end = frame_end || in_last;
`endif
    cnt_d = frame_end ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DATA;
      cnt_q       <= '0;
      lrc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_par_q   <= 1'b0;
      out_trl_q   <= 1'b0;
    end else if (accept) begin
      out_data_q  <= in_data;
      out_par_q   <= in_par ^ mode_odd;
      out_trl_q   <= 1'b0;
      out_valid_q <= 1'b1;
      lrc_q       <= lrc_q ^ in_data;
      cnt_q       <= cnt_d;
      if (frame_end) state_q <= ST_TRAILER;
    end else if (state_q == ST_TRAILER && slot_free) begin
      // Trailer parity uses mode_odd as of this load, not the last word's.
      out_data_q  <= lrc_q;
      out_par_q   <= lrc_par ^ mode_odd;
      out_trl_q   <= 1'b1;
      out_valid_q <= 1'b1;
      lrc_q       <= '0;
      state_q     <= ST_DATA;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_par        = out_par_q;
  assign out_is_trailer = out_trl_q;

endmodule
